// File: rtl/clock_pkg.sv
// Shared state codes and counter-width helper for the clock set controller.
package clock_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] RUN      = 2'd0;
    localparam logic [MODE_W-1:0] SET_HOUR = 2'd1;
    localparam logic [MODE_W-1:0] SET_MIN  = 2'd2;
    localparam logic [MODE_W-1:0] SET_SEC  = 2'd3;

    // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and counter-control outputs of the clock set controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic              TICK_1HZ;
    logic              BTN_MODE;
    logic              BTN_UP;
    logic              BTN_DOWN;
    logic              SEC_CARRY;
    logic              MIN_CARRY;
    logic              EN_SEC;
    logic              EN_MIN;
    logic              EN_HOUR;
    logic              CIN_SEC;
    logic              CIN_MIN;
    logic              CIN_HOUR;
    logic              DEC;
    logic              BLANK_SEC;
    logic              BLANK_MIN;
    logic              BLANK_HOUR;
    logic [MODE_W-1:0] MODE;

    modport master (
        input  TICK_1HZ, BTN_MODE, BTN_UP, BTN_DOWN, SEC_CARRY, MIN_CARRY,
        output EN_SEC, EN_MIN, EN_HOUR, CIN_SEC, CIN_MIN, CIN_HOUR, DEC,
               BLANK_SEC, BLANK_MIN, BLANK_HOUR, MODE
    );

    modport slave (
        output TICK_1HZ, BTN_MODE, BTN_UP, BTN_DOWN, SEC_CARRY, MIN_CARRY,
        input  EN_SEC, EN_MIN, EN_HOUR, CIN_SEC, CIN_MIN, CIN_HOUR, DEC,
               BLANK_SEC, BLANK_MIN, BLANK_HOUR, MODE
    );

endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Button front end: 2-FF synchroniser, rising-edge detector and auto-repeat timer.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 25000000,
    parameter int unsigned REPEAT_PER = 5000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn,
    input  logic clr,
    output logic lvl,
    output logic evt_c
);

    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CNT_W   = cnt_width(RPT_MAX);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             first;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             rep;
    logic [CNT_W-1:0] limit;

    assign lvl   = sync2;
    assign rise  = sync2 & ~prev;
    assign limit = first ? CNT_W'(REPEAT_DLY - 1) : CNT_W'(REPEAT_PER - 1);
    assign rep   = sync2 & ~rise & ~clr & (cnt == limit);
    assign evt_c = rise | rep;

    // First repeat waits REPEAT_DLY, later ones REPEAT_PER; any clear restarts the long wait.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            first <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            if (clr || !sync2 || rise) begin
                cnt   <= '0;
                first <= 1'b1;
            end else if (rep) begin
                cnt   <= '0;
                first <= 1'b0;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-setting controller: chains the counters in RUN, steps one field in SET states.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DLY    = 25000000,
    parameter int unsigned REPEAT_PER    = 5000000,
    parameter int unsigned BLINK_HALF    = 12500000,
    parameter int unsigned TIMEOUT_TICKS = 30
) (
    input  logic             CLK,
    input  logic             RESET,
    clock_set_ctrl_if.master bus
);

    localparam int unsigned TO_W = cnt_width(TIMEOUT_TICKS);
    localparam int unsigned BL_W = cnt_width(BLINK_HALF);

    logic [MODE_W-1:0] state;
    logic [MODE_W-1:0] next_state;
    logic              mode_lvl;
    logic              mode_evt;
    logic              up_lvl;
    logic              up_evt;
    logic              dn_lvl;
    logic              dn_evt;
    logic              both;
    logic              rpt_clr;
    logic              activity;
    logic              step_req;
    logic              step;
    logic              dir;
    logic              phase;
    logic [BL_W-1:0]   blink_cnt;
    logic [TO_W-1:0]   to_cnt;

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_mode (
        .CLK(CLK), .RESET(RESET), .btn(bus.BTN_MODE), .clr(1'b1),
        .lvl(mode_lvl), .evt_c(mode_evt)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
        .CLK(CLK), .RESET(RESET), .btn(bus.BTN_UP), .clr(rpt_clr),
        .lvl(up_lvl), .evt_c(up_evt)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn (
        .CLK(CLK), .RESET(RESET), .btn(bus.BTN_DOWN), .clr(rpt_clr),
        .lvl(dn_lvl), .evt_c(dn_evt)
    );

    // Repeat is suppressed in RUN, with both directions held, and while MODE is held.
    assign both     = up_lvl & dn_lvl;
    assign rpt_clr  = (state == RUN) | both | mode_lvl;
    assign activity = mode_evt | up_evt | dn_evt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= RUN;
        else       state <= next_state;
    end

    // Next state and step request; a step is dropped when the state changes in that cycle.
    always_comb begin
        next_state = state;
        step_req   = 1'b0;
        if (mode_evt) begin
            case (state)
                RUN:      next_state = SET_HOUR;
                SET_HOUR: next_state = SET_MIN;
                SET_MIN:  next_state = SET_SEC;
                SET_SEC:  next_state = RUN;
            endcase
        end else if ((state != RUN) && bus.TICK_1HZ && !activity &&
                     (to_cnt == TO_W'(TIMEOUT_TICKS - 1))) begin
            next_state = RUN;
        end
        step_req = (state != RUN) && !mode_evt && !both && (up_evt || dn_evt) &&
                   (next_state == state);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step <= 1'b0;
            dir  <= 1'b0;
        end else begin
            step <= step_req;
            if (step_req)                dir <= ~up_evt;
            else if (next_state == RUN)  dir <= 1'b0;
        end
    end

    // Inactivity timer counts ticks only while editing with no button activity.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt <= '0;
        end else if ((state == RUN) || activity || (next_state != state)) begin
            to_cnt <= '0;
        end else if (bus.TICK_1HZ) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Blink phase restarts (digits visible) on entering a SET state and on each step.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if ((next_state == RUN) || (next_state != state) || step_req) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

    // Counter control: chained clock in RUN, single selected field otherwise.
    always_comb begin
        bus.EN_SEC     = 1'b0;
        bus.EN_MIN     = 1'b0;
        bus.EN_HOUR    = 1'b0;
        bus.CIN_SEC    = 1'b0;
        bus.CIN_MIN    = 1'b0;
        bus.CIN_HOUR   = 1'b0;
        bus.DEC        = 1'b0;
        bus.BLANK_SEC  = 1'b0;
        bus.BLANK_MIN  = 1'b0;
        bus.BLANK_HOUR = 1'b0;
        bus.MODE       = state;
        case (state)
            RUN: begin
                bus.EN_SEC   = 1'b1;
                bus.EN_MIN   = 1'b1;
                bus.EN_HOUR  = 1'b1;
                bus.CIN_SEC  = bus.TICK_1HZ;
                bus.CIN_MIN  = bus.SEC_CARRY;
                bus.CIN_HOUR = bus.SEC_CARRY & bus.MIN_CARRY;
            end
            SET_HOUR: begin
                bus.EN_HOUR    = 1'b1;
                bus.CIN_HOUR   = step;
                bus.DEC        = dir;
                bus.BLANK_HOUR = phase;
            end
            SET_MIN: begin
                bus.EN_MIN    = 1'b1;
                bus.CIN_MIN   = step;
                bus.DEC       = dir;
                bus.BLANK_MIN = phase;
            end
            SET_SEC: begin
                bus.EN_SEC    = 1'b1;
                bus.CIN_SEC   = step;
                bus.DEC       = dir;
                bus.BLANK_SEC = phase;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed test-plan steps plus randomized button/tick traffic against a behavioural model.
module tb_clock_set_ctrl;

    localparam int DLY = 8;
    localparam int PER = 3;
    localparam int BH  = 4;
    localparam int TT  = 3;

    // Bit positions in the sampled output vector.
    localparam int B_EN_SEC  = 11;
    localparam int B_EN_MIN  = 10;
    localparam int B_EN_HOUR = 9;
    localparam int B_CIN_SEC = 8;
    localparam int B_CIN_MIN = 7;
    localparam int B_CIN_HR  = 6;
    localparam int B_DEC     = 5;
    localparam int B_BL_HOUR = 2;
    localparam int B_BL_MIN  = 3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .BLINK_HALF(BH), .TIMEOUT_TICKS(TT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: state by field meaning, button history as raw-level shift lines,
    // repeat and blink timing as arithmetic on cycle stamps.
    int        cyc;
    int        st;
    bit        m_step;
    bit        m_dir;
    int        idle;
    int        blink_base;
    int        start_u;
    int        start_d;
    bit [3:0]  hm, hu, hd;
    logic [11:0] obs_v;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        cyc = 0; st = 0; m_step = 0; m_dir = 0; idle = 0; blink_base = 0;
        start_u = 0; start_d = 0; hm = '0; hu = '0; hd = '0;
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        bus.TICK_1HZ = 0; bus.BTN_MODE = 0; bus.BTN_UP = 0; bus.BTN_DOWN = 0;
        bus.SEC_CARRY = 0; bus.MIN_CARRY = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_init();
        @(posedge CLK);
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step_cycle(input bit t, input bit m, input bit u, input bit d,
                              input bit sc, input bit mc);
        logic [11:0] exp_v;
        logic [2:0]  en, cin, blk;
        bit dec, ph;
        bit lvl_m, lvl_u, lvl_d, rise_m, rise_u, rise_d, both, clr;
        bit rep_u, rep_d, evt_u, evt_d, act, stp, dir_n;
        int ns, idle_n;
        @(negedge CLK);
        bus.TICK_1HZ = t; bus.BTN_MODE = m; bus.BTN_UP = u; bus.BTN_DOWN = d;
        bus.SEC_CARRY = sc; bus.MIN_CARRY = mc;
        hm = {hm[2:0], m}; hu = {hu[2:0], u}; hd = {hd[2:0], d};
        #1;
        ph  = (st != 0) && ((((cyc - blink_base) / BH) % 2) == 1);
        dec = 1'b0; en = 3'b000; cin = 3'b000; blk = 3'b000;
        case (st)
            0: begin en = 3'b111; cin = {t, sc, sc & mc}; end
            1: begin en = 3'b001; cin = {2'b00, m_step}; blk = {2'b00, ph}; dec = m_dir; end
            2: begin en = 3'b010; cin = {1'b0, m_step, 1'b0}; blk = {1'b0, ph, 1'b0}; dec = m_dir; end
            default: begin en = 3'b100; cin = {m_step, 2'b00}; blk = {ph, 2'b00}; dec = m_dir; end
        endcase
        exp_v = {en, cin, dec, blk, 2'(st)};
        obs_v = {bus.EN_SEC, bus.EN_MIN, bus.EN_HOUR, bus.CIN_SEC, bus.CIN_MIN, bus.CIN_HOUR,
                 bus.DEC, bus.BLANK_SEC, bus.BLANK_MIN, bus.BLANK_HOUR, bus.MODE};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL cycle%0d outputs observed=%b expected=%b", cyc, obs_v, exp_v);
        end

        // A button is seen two cycles after the raw level; a press is a new high level.
        lvl_m = hm[2]; rise_m = hm[2] & ~hm[3];
        lvl_u = hu[2]; rise_u = hu[2] & ~hu[3];
        lvl_d = hd[2]; rise_d = hd[2] & ~hd[3];
        both  = lvl_u & lvl_d;
        clr   = (st == 0) | both | lvl_m;
        rep_u = lvl_u & ~rise_u & ~clr & (cyc - start_u >= DLY) && ((cyc - start_u - DLY) % PER == 0);
        rep_d = lvl_d & ~rise_d & ~clr & (cyc - start_d >= DLY) && ((cyc - start_d - DLY) % PER == 0);
        if (rise_u | clr | ~lvl_u) start_u = cyc;
        if (rise_d | clr | ~lvl_d) start_d = cyc;
        evt_u = rise_u | rep_u;
        evt_d = rise_d | rep_d;
        act   = rise_m | evt_u | evt_d;

        ns = st;
        if (rise_m) ns = (st + 1) % 4;
        else if (st != 0 && t && !act && idle == TT - 1) ns = 0;
        stp    = (st != 0) && !rise_m && !both && (evt_u || evt_d) && (ns == st);
        idle_n = (st == 0 || act || ns != st) ? 0 : (t ? idle + 1 : idle);
        dir_n  = stp ? evt_d : ((ns == 0) ? 1'b0 : m_dir);
        if (ns != 0 && (ns != st || stp)) blink_base = cyc + 1;

        @(posedge CLK);
        st = ns; m_step = stp; m_dir = dir_n; idle = idle_n;
        cyc++;
    endtask

    task automatic press_mode();
        step_cycle(0, 1, 0, 0, 0, 0);
        step_cycle(0, 1, 0, 0, 0, 0);
        repeat (4) step_cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n, cm_cnt, ok;
        int steps[$];
        bit decs[$];
        bit bm[20];
        bit cm[20];
        bit ch;
        int s;
        bit u, d, m;
        logic [3:0] snap;

        reset_dut();
        chk("reset_mode", int'(bus.MODE), 0);
        chk("reset_dec", int'(bus.DEC), 0);
        chk("reset_en", int'({bus.EN_SEC, bus.EN_MIN, bus.EN_HOUR}), 7);

        // 1: running clock, carry chain pass-through on the 60th tick
        cm_cnt = 0; ok = 1;
        for (int i = 1; i <= 60; i++) begin
            step_cycle(1, 0, 0, 0, (i == 60), 0);
            if (obs_v[B_CIN_MIN]) cm_cnt++;
            if (obs_v[B_EN_SEC:B_EN_HOUR] !== 3'b111 || obs_v[B_DEC] !== 1'b0 || obs_v[B_CIN_SEC] !== 1'b1) ok = 0;
            if (i == 60) chk("t1_cin_min_60th", int'(obs_v[B_CIN_MIN]), 1);
            step_cycle(0, 0, 0, 0, 0, 0);
            if (obs_v[B_EN_SEC:B_EN_HOUR] !== 3'b111 || obs_v[B_CIN_SEC] !== 1'b0) ok = 0;
        end
        chk("t1_cin_min_count", cm_cnt, 1);
        chk("t1_run_outputs", ok, 1);

        // 2: enter SET_HOUR, single UP step
        press_mode();
        chk("t2_mode", int'(bus.MODE), 1);
        n = 0; snap = 4'hF;
        for (int i = 0; i < 12; i++) begin
            step_cycle(0, 0, (i < 2), 0, 0, 0);
            if (obs_v[B_CIN_HR]) begin
                n++;
                snap = {obs_v[B_DEC], obs_v[B_EN_MIN], obs_v[B_EN_SEC], obs_v[B_BL_HOUR]};
            end
        end
        chk("t2_step_count", n, 1);
        chk("t2_step_fields", int'(snap), 0);

        // 3: DOWN held 20 cycles, auto-repeat timing
        for (int i = 0; i < 30; i++) begin
            step_cycle(0, 0, 0, (i < 20), 0, 0);
            if (obs_v[B_CIN_HR]) begin
                steps.push_back(i);
                decs.push_back(obs_v[B_DEC]);
            end
        end
        chk("t3_step_count", steps.size(), 5);
        if (steps.size() == 5) begin
            chk("t3_step0", steps[0], 3);
            chk("t3_step1", steps[1], 11);
            chk("t3_step2", steps[2], 14);
            chk("t3_step3", steps[3], 17);
            chk("t3_step4", steps[4], 20);
            for (int k = 0; k < 5; k++) chk("t3_dec", int'(decs[k]), 1);
        end

        // 4: SET_MIN, UP and DOWN together
        press_mode();
        chk("t4_mode", int'(bus.MODE), 2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step_cycle(0, 0, (i < 15), (i < 15), 0, 0);
            if (obs_v[B_CIN_SEC:B_CIN_HR] != 3'b000) n++;
        end
        chk("t4_no_cin", n, 0);

        // 5: SET_SEC inactivity timeout
        press_mode();
        chk("t5_mode", int'(bus.MODE), 3);
        for (int i = 0; i < 10; i++) begin
            step_cycle((i == 1 || i == 4 || i == 7), 0, 0, 0, 0, 0);
            if (i == 7) chk("t5_mode_at_3rd_tick", int'(obs_v[1:0]), 3);
            if (i == 8) begin
                chk("t5_mode_after", int'(obs_v[1:0]), 0);
                chk("t5_dec_after", int'(obs_v[B_DEC]), 0);
            end
        end

        // 6: SET_MIN step with carries high, no hour propagation, blink restart
        press_mode();
        press_mode();
        chk("t6_mode", int'(bus.MODE), 2);
        ch = 0;
        for (int i = 0; i < 20; i++) begin
            step_cycle(0, 0, (i < 2), 0, 1, 1);
            cm[i] = obs_v[B_CIN_MIN];
            bm[i] = obs_v[B_BL_MIN];
            ch |= obs_v[B_CIN_HR];
        end
        s = -1;
        for (int i = 19; i >= 0; i--) if (cm[i]) s = i;
        chk("t6_step_at", s, 3);
        chk("t6_cin_hour", int'(ch), 0);
        chk("t6_blank_step", int'(bm[3]), 0);
        chk("t6_blank_s6", int'(bm[6]), 0);
        chk("t6_blank_s7", int'(bm[7]), 1);
        chk("t6_blank_s10", int'(bm[10]), 1);
        chk("t6_blank_s11", int'(bm[11]), 0);

        // Randomized traffic checked cycle by cycle against the model
        u = 0; d = 0; m = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) u = ~u;
            if ($urandom_range(0, 11) == 0) d = ~d;
            if ($urandom_range(0, 15) == 0) m = ~m;
            step_cycle(($urandom_range(0, 5) == 0), m, u, d,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of activity
        step_cycle(0, 0, 1, 0, 0, 0);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_mode", int'(bus.MODE), 0);
        chk("async_reset_dec", int'(bus.DEC), 0);
        chk("async_reset_blank", int'({bus.BLANK_SEC, bus.BLANK_MIN, bus.BLANK_HOUR}), 0);
        @(negedge CLK);
        RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode and time-setting controller for the digital clock datapath.
- Sits between the button inputs, the 1 Hz tick and the three counter blocks: seconds mod-60, minutes mod-60, hours mod-24.
- Drives each counter's ENABLE, CARRY_in and DEC so the counters either run as a chained clock or are stepped one field at a time.
- Adds auto-repeat on held buttons, an inactivity timeout and a blink control for the field being edited.

Parameters:
- REPEAT_DLY, 25000000: CLK cycles a button is held before the first auto-repeat step.
- REPEAT_PER, 5000000: CLK cycles between later auto-repeat steps.
- BLINK_HALF, 12500000: CLK cycles per blink half-period.
- TIMEOUT_TICKS, 30: TICK_1HZ pulses with no button press before a set mode returns to RUN.

Ports:
- CLK, in, 1: system clock.
- RESET, in, 1: asynchronous active-high reset.
- TICK_1HZ, in, 1: one-CLK-cycle pulse, once per second.
- BTN_MODE, in, 1: raw level, already debounced, asynchronous to CLK.
- BTN_UP, in, 1: raw level, already debounced, asynchronous to CLK.
- BTN_DOWN, in, 1: raw level, already debounced, asynchronous to CLK.
- SEC_CARRY, in, 1: CARRY_out of the seconds counter.
- MIN_CARRY, in, 1: CARRY_out of the minutes counter.
- EN_SEC, out, 1: ENABLE for the seconds counter.
- EN_MIN, out, 1: ENABLE for the minutes counter.
- EN_HOUR, out, 1: ENABLE for the hours counter.
- CIN_SEC, out, 1: CARRY_in for the seconds counter.
- CIN_MIN, out, 1: CARRY_in for the minutes counter.
- CIN_HOUR, out, 1: CARRY_in for the hours counter.
- DEC, out, 1: count direction to all counters (1 = down).
- BLANK_SEC, out, 1: 1 = blank the seconds digits (blink).
- BLANK_MIN, out, 1: 1 = blank the minutes digits (blink).
- BLANK_HOUR, out, 1: 1 = blank the hours digits (blink).
- MODE, out, 2: current state code.

Behaviour:
- Clock and reset: single clock CLK; RESET is asynchronous, active-high.
- State on reset: RUN. All registered signals clear to 0: step, step direction, repeat counter, blink counter and phase, timeout counter, synchronisers.
- States and MODE codes: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.

Button input path:
- Each button passes through a 2-FF synchroniser, then a rising-edge detector.
- A press registers its effect 3 CLK edges after the raw input rises.

Mode transitions:
- A MODE press advances RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- Timeout: in any SET state, TIMEOUT_TICKS TICK_1HZ pulses with no press of any button forces RUN.
- The timeout counter clears on every press and on every state change.

Step generation (SET states only):
- An UP or DOWN press produces a registered one-cycle STEP with DIR = 0 for UP, 1 for DOWN.
- Held button: first repeat STEP after REPEAT_DLY cycles, then one STEP every REPEAT_PER cycles until release.
- UP and DOWN both high: no STEP; the repeat counter is held in reset.
- A MODE press has priority over UP/DOWN in the same cycle: the state advances, no STEP, repeat cancels.
- UP/DOWN are ignored in RUN.

Output mapping in RUN (combinational from the state register and the inputs):
- EN_SEC = EN_MIN = EN_HOUR = 1.
- DEC = 0.
- CIN_SEC = TICK_1HZ, CIN_MIN = SEC_CARRY, CIN_HOUR = SEC_CARRY & MIN_CARRY.
- CIN_MIN and CIN_HOUR are zero-latency pass-throughs, so the whole chain updates on the same edge.

Output mapping in SET_x:
- Only the selected field's EN is 1; the other two ENs are 0.
- The selected field's CIN = STEP; the other CINs are 0.
- TICK_1HZ and the carry inputs are ignored, so time is frozen.
- Wrap-around inside the field is the counter's own behaviour. Examples: 23 up -> 00, 00 down -> 23, 59 up -> 00.
- Rollover never propagates: a minutes wrap in SET_MIN does not touch the hours counter.
- DEC = DIR, registered together with STEP and held until the next STEP.
- DEC is forced to 0 on entry to RUN.

Blink:
- The phase toggles every BLINK_HALF cycles.
- BLANK_x = (state == SET_x) & phase.
- The phase clears to 0 (digits shown) on entry to any SET state and on every STEP.
- All BLANK_x are 0 in RUN.

Boundary cases:
- Reset mid-STEP: the pulse is lost and the counters are reset by the same RESET.
- TICK_1HZ coincident with a MODE press leaving SET_SEC: the next cycle is RUN; that tick is not counted.
- A timeout tick coincident with an UP press: the press wins; the counter clears and the state stays.

Decomposition:
- Shared package clock_pkg holds:
  - state localparams RUN, SET_HOUR, SET_MIN, SET_SEC as 2-bit codes;
  - the counter-width helper that uses $clog2 of the parameters.
- One natural sub-module, btn_repeat: synchroniser, edge detector and auto-repeat timer. It is instantiated for UP and for DOWN; MODE uses the sync and edge stages only.

Test Plan (REPEAT_DLY=8, REPEAT_PER=3, BLINK_HALF=4, TIMEOUT_TICKS=3):
1. Reset, then RUN with 60 TICK_1HZ pulses and SEC_CARRY asserted on the 60th -> CIN_MIN=1 in exactly that cycle; EN_*=1 and DEC=0 throughout.
2. MODE pressed once, UP pulsed 2 cycles -> MODE=1, exactly one STEP: CIN_HOUR=1 for 1 cycle, DEC=0, EN_MIN=EN_SEC=0, BLANK_HOUR=0 that cycle.
3. SET_HOUR, DOWN held 20 cycles -> STEPs at press+3, +11, +14, +17, +20 (press = raw rise), DEC=1 with each.
4. SET_MIN, UP and DOWN high together for 15 cycles -> no CIN pulses at all.
5. SET_SEC, 3 TICK_1HZ pulses with no press -> MODE=0 on the cycle after the 3rd tick, DEC=0.
6. SET_MIN with a STEP at minutes 59 and MIN_CARRY=1 -> CIN_HOUR stays 0; BLANK_MIN toggles every 4 cycles and is 0 after the STEP.
